// File: rtl/aes_sbox_sched.sv
// ---------------------------------------------------------------------------
// aes_sbox_sched
//
// Time-shares NUM_SBOX AES S-box lookups between two requesters: the round
// datapath (SubBytes over a 128-bit state) and the key schedule (SubWord over
// a 32-bit word). A granted operand is captured into a buffer and pushed
// through the S-boxes NUM_SBOX bytes per cycle. Results land in per-requester
// output registers, and a one-cycle done strobe marks completion.
//
// Parameters
//   NUM_SBOX  S-box lanes used per cycle (1, 2 or 4)
//
// Configuration macro
//   SBOX_SCHED_RR_EN  defined  : round-robin arbitration when both requests
//                                are high
//                     undefined: fixed priority, key word wins
//
// Ports
//   clk      clock
//   reset    synchronous active-high reset
//   st_req   state SubBytes request (level)
//   st_in    128-bit state operand, byte i = st_in[8i+7:8i]
//   st_gnt   combinational pulse: st_in is captured this cycle
//   st_done  registered pulse: st_out is complete
//   st_out   SubBytes result
//   kw_req   key-word SubWord request (level)
//   kw_in    32-bit key word operand, byte i = kw_in[8i+7:8i]
//   kw_gnt   combinational pulse: kw_in is captured this cycle
//   kw_done  registered pulse: kw_out is complete
//   kw_out   SubWord result
//   busy     high while a conversion is running
// ---------------------------------------------------------------------------
module aes_sbox_sched #(
  parameter int NUM_SBOX = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         st_req,
  input  logic [127:0] st_in,
  output logic         st_gnt,
  output logic         st_done,
  output logic [127:0] st_out,
  input  logic         kw_req,
  input  logic [31:0]  kw_in,
  output logic         kw_gnt,
  output logic         kw_done,
  output logic [31:0]  kw_out,
  output logic         busy
);

  localparam int ST_N  = 16 / NUM_SBOX;
  localparam int KW_N  = 4 / NUM_SBOX;
  localparam int CNT_W = $clog2(ST_N);

  generate
    if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4) begin : g_bad_num_sbox
      $fatal(1, "aes_sbox_sched: NUM_SBOX must be 1, 2 or 4");
    end
  endgenerate

  // AES forward S-box. Row = high nibble (y), column = low nibble (x).
  // Ascending packed range so entry 0 is the leftmost byte of the literal.
  localparam logic [0:255][7:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN_ST = 2'd1,
    RUN_KW = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg;
  logic [15:0][7:0]     buf_reg;
  logic [15:0][7:0]     st_out_reg;
  logic [3:0][7:0]      kw_out_reg;
  logic                 st_done_reg, kw_done_reg;

  logic                 grant_st, grant_kw;
  logic                 last_batch;
  logic                 kw_pref;

  logic [3:0]           lane_idx [NUM_SBOX];
  logic [7:0]           lane_res [NUM_SBOX];

`ifdef SBOX_SCHED_RR_EN
  // 0: state requester served last, 1: key word served last.
  logic                 last_served_reg;
  assign kw_pref = ~last_served_reg;
`else
  assign kw_pref = 1'b1;
`endif

  // Each lane handles one byte of the current batch.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SBOX; gi++) begin : g_lane
      assign lane_idx[gi] = 4'(cnt_reg) * 4'(NUM_SBOX) + 4'(gi);
      assign lane_res[gi] = SBOX_TAB[buf_reg[lane_idx[gi]]];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    grant_st   = 1'b0;
    grant_kw   = 1'b0;
    last_batch = 1'b0;
    case (state_reg)
      IDLE: begin
        // kw_pref only matters on a conflict; a lone request always wins.
        if (kw_req && (!st_req || kw_pref)) begin
          grant_kw   = 1'b1;
          state_next = RUN_KW;
        end else if (st_req) begin
          grant_st   = 1'b1;
          state_next = RUN_ST;
        end
      end
      RUN_ST: begin
        last_batch = (cnt_reg == CNT_W'(ST_N - 1));
        if (last_batch) state_next = IDLE;
      end
      RUN_KW: begin
        last_batch = (cnt_reg == CNT_W'(KW_N - 1));
        if (last_batch) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      buf_reg         <= '0;
      st_out_reg      <= '0;
      kw_out_reg      <= '0;
      st_done_reg     <= 1'b0;
      kw_done_reg     <= 1'b0;
`ifdef SBOX_SCHED_RR_EN
      last_served_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      st_done_reg <= 1'b0;
      kw_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_kw) begin
            buf_reg <= {96'b0, kw_in};
            cnt_reg <= '0;
          end else if (grant_st) begin
            buf_reg <= st_in;
            cnt_reg <= '0;
          end
`ifdef SBOX_SCHED_RR_EN
          if (grant_kw)      last_served_reg <= 1'b1;
          else if (grant_st) last_served_reg <= 1'b0;
`endif
        end
        RUN_ST: begin
          for (int i = 0; i < NUM_SBOX; i++) begin
            st_out_reg[lane_idx[i]] <= lane_res[i];
          end
          // Counter is cleared rather than incremented on the final batch
          // so it never wraps.
          cnt_reg     <= last_batch ? '0 : cnt_reg + CNT_W'(1);
          st_done_reg <= last_batch;
        end
        RUN_KW: begin
          for (int i = 0; i < NUM_SBOX; i++) begin
            kw_out_reg[lane_idx[i][1:0]] <= lane_res[i];
          end
          cnt_reg     <= last_batch ? '0 : cnt_reg + CNT_W'(1);
          kw_done_reg <= last_batch;
        end
        default: cnt_reg <= '0;
      endcase
    end
  end

  assign st_gnt  = grant_st;
  assign kw_gnt  = grant_kw;
  assign st_done = st_done_reg;
  assign kw_done = kw_done_reg;
  assign st_out  = st_out_reg;
  assign kw_out  = kw_out_reg;
  assign busy    = (state_reg != IDLE);

endmodule
